// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer driving an external 8-bit universal shift register.
// Handles the byte handshake, SCLK/CS_n/MOSI generation, MISO sampling and the received-byte pulse.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic       i_hold_cs,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_busy,
  output logic       o_sclk,
  output logic       o_cs_n,
  output logic       o_mosi,
  input  logic       i_miso,
  output logic [1:0] o_sr_mode,
  output logic       o_sr_oe_n,
  output logic [7:0] o_sr_parallel,
  output logic       o_sr_serial,
  input  logic [7:0] i_sr_parallel
);

  localparam int CMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, DONE, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic          cs_held;
  logic          half_end;
  logic          gap_end;

  assign half_end = (cnt == HALF_LAST);
  assign gap_end  = (cnt == GAP_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      cs_held       <= 1'b0;
      o_sr_parallel <= '0;
      o_sr_serial   <= 1'b0;
      o_rx_data     <= '0;
      o_rx_valid    <= 1'b0;
    end else begin
      state      <= state_nxt;
      // One counter serves both half-periods and the CS gap; it restarts on every state change.
      cnt        <= (state_nxt != state) ? '0 : cnt + CW'(1);
      o_rx_valid <= (state == DONE);
      if (state == IDLE && i_tx_valid) begin
        o_sr_parallel <= i_tx_data;
        bit_cnt       <= '0;
      end
      if (state == LOW && half_end)
        o_sr_serial <= i_miso;
      if (state == HIGH && half_end)
        bit_cnt <= bit_cnt + 3'd1;
      if (state == DONE) begin
        o_rx_data <= i_sr_parallel;
        cs_held   <= i_hold_cs;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    o_tx_ready = 1'b0;
    o_busy     = 1'b1;
    o_sclk     = 1'b0;
    o_cs_n     = 1'b0;
    o_mosi     = 1'b0;
    o_sr_mode  = 2'b00;
    o_sr_oe_n  = 1'b0;
    case (state)
      IDLE: begin
        o_tx_ready = i_rst_n;
        o_busy     = 1'b0;
        o_sr_oe_n  = 1'b1;
        o_cs_n     = ~cs_held;
        if (i_tx_valid) state_nxt = LOAD;
      end
      LOAD: begin
        o_sr_mode = 2'b11;
        state_nxt = LOW;
      end
      LOW: begin
        o_mosi = i_sr_parallel[7];
        if (half_end) state_nxt = HIGH;
      end
      HIGH: begin
        o_sclk = 1'b1;
        o_mosi = i_sr_parallel[7];
        // The shift lands on the final HIGH cycle so MOSI stays stable for the whole high phase.
        if (half_end) begin
          o_sr_mode = 2'b10;
          state_nxt = (bit_cnt == 3'd7) ? DONE : LOW;
        end
      end
      DONE: begin
        state_nxt = i_hold_cs ? IDLE : GAP;
      end
      GAP: begin
        o_cs_n    = 1'b1;
        o_sr_oe_n = 1'b1;
        if (gap_end) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        o_busy    = 1'b0;
        o_cs_n    = 1'b1;
        o_sr_oe_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: CLK_DIV=4 and CLK_DIV=1 instances share one SPI slave model.
// Expected bytes, latency and edge counts come from the protocol rules, not from the RTL.
module tb_spi_master_ctrl;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;
  localparam int GAP_C = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tx_valid, hold_cs, sel, loopback;
  logic [7:0] tx_data, slave_byte, slave_rx;
  logic [2:0] fall_cnt;
  logic       miso;
  int         checks = 0;
  int         fails  = 0;

  logic       ready_a, rxv_a, busy_a, sclk_a, cs_a, mosi_a, oe_a, ser_a;
  logic [7:0] rxd_a, par_a, q_a, srin_a;
  logic [1:0] mode_a;
  logic       ready_b, rxv_b, busy_b, sclk_b, cs_b, mosi_b, oe_b, ser_b;
  logic [7:0] rxd_b, par_b, q_b, srin_b;
  logic [1:0] mode_b;
  logic       valid_a, valid_b;

  assign valid_a = tx_valid & ~sel;
  assign valid_b = tx_valid & sel;

  spi_master_ctrl #(.CLK_DIV(DIV_A), .CS_GAP(GAP_C)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_valid(valid_a),
    .o_tx_ready(ready_a), .i_hold_cs(hold_cs), .o_rx_data(rxd_a), .o_rx_valid(rxv_a),
    .o_busy(busy_a), .o_sclk(sclk_a), .o_cs_n(cs_a), .o_mosi(mosi_a), .i_miso(miso),
    .o_sr_mode(mode_a), .o_sr_oe_n(oe_a), .o_sr_parallel(par_a), .o_sr_serial(ser_a),
    .i_sr_parallel(srin_a));

  spi_master_ctrl #(.CLK_DIV(DIV_B), .CS_GAP(GAP_C)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_valid(valid_b),
    .o_tx_ready(ready_b), .i_hold_cs(hold_cs), .o_rx_data(rxd_b), .o_rx_valid(rxv_b),
    .o_busy(busy_b), .o_sclk(sclk_b), .o_cs_n(cs_b), .o_mosi(mosi_b), .i_miso(miso),
    .o_sr_mode(mode_b), .o_sr_oe_n(oe_b), .o_sr_parallel(par_b), .o_sr_serial(ser_b),
    .i_sr_parallel(srin_b));

  // Behavioural universal shift registers: 11 load, 10 shift left with serial in, else hold.
  always @(posedge clk) begin
    if (!rst_n) q_a <= 8'h00;
    else if (mode_a == 2'b11) q_a <= par_a;
    else if (mode_a == 2'b10) q_a <= {q_a[6:0], ser_a};
  end
  always @(posedge clk) begin
    if (!rst_n) q_b <= 8'h00;
    else if (mode_b == 2'b11) q_b <= par_b;
    else if (mode_b == 2'b10) q_b <= {q_b[6:0], ser_b};
  end
  assign srin_a = oe_a ? 8'h00 : q_a;
  assign srin_b = oe_b ? 8'h00 : q_b;

  logic       ready, rxv, busy, sclk, cs, mosi, oe;
  logic [7:0] rxd;
  logic [1:0] mode;
  assign ready = sel ? ready_b : ready_a;
  assign rxv   = sel ? rxv_b   : rxv_a;
  assign busy  = sel ? busy_b  : busy_a;
  assign sclk  = sel ? sclk_b  : sclk_a;
  assign cs    = sel ? cs_b    : cs_a;
  assign mosi  = sel ? mosi_b  : mosi_a;
  assign oe    = sel ? oe_b    : oe_a;
  assign rxd   = sel ? rxd_b   : rxd_a;
  assign mode  = sel ? mode_b  : mode_a;

  // Mode-0 slave: captures MOSI on SCLK rise, presents its next bit after each SCLK fall.
  always @(posedge sclk) slave_rx <= {slave_rx[6:0], mosi};
  always @(negedge sclk or posedge cs) begin
    if (cs) fall_cnt <= 3'd0;
    else    fall_cnt <= fall_cnt + 3'd1;
  end
  assign miso = loopback ? mosi : slave_byte[3'd7 - fall_cnt];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer on the selected instance, checked against the protocol rules.
  task automatic applyStimulus(input bit s, input logic [7:0] tx, input logic [7:0] slv,
                               input bit lb, input bit hold, input bit busy_req);
    int         lat, rises, gap, div;
    bit         cs_ok, rdy_ok, done;
    logic       prev_sclk;
    logic [7:0] exp_rx;
    exp_rx     = lb ? tx : slv;
    div        = s ? DIV_B : DIV_A;
    sel        = s;
    loopback   = lb;
    slave_byte = slv;
    hold_cs    = hold;
    for (int i = 0; i < 100 && !ready; i++) tick();
    checkOutput("ready_before", ready, 1);
    tx_data  = tx;
    tx_valid = 1'b1;
    tick();
    if (busy_req) tx_data = 8'hFF;
    else          tx_valid = 1'b0;
    lat = 0; rises = 0; done = 0; rdy_ok = !ready; cs_ok = !cs; prev_sclk = sclk;
    for (int e = 1; e <= 300 && !done; e++) begin
      tick();
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (rxv) begin
        done = 1;
        lat  = e;
      end else begin
        if (cs)    cs_ok  = 0;
        if (ready) rdy_ok = 0;
      end
    end
    tx_valid = 1'b0;
    checkOutput("rx_seen", done, 1);
    checkOutput("latency", lat, 2 + 16 * div);
    checkOutput("rx_data", rxd, exp_rx);
    checkOutput("slave_rx", slave_rx, tx);
    checkOutput("sclk_rises", rises, 8);
    checkOutput("cs_low", cs_ok, 1);
    if (busy_req) checkOutput("not_ready_busy", rdy_ok, 1);
    if (hold) checkOutput("held_cs_ready", {cs, ready}, 2'b01);
    gap = (!hold && cs) ? 1 : 0;
    tick();
    checkOutput("rx_pulse", rxv, 0);
    if (!hold) begin
      for (int i = 0; i < 20 && !ready; i++) begin
        if (cs) gap++;
        tick();
      end
      checkOutput("cs_gap", gap, GAP_C);
      checkOutput("idle_cs_high", {cs, ready}, 2'b11);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   rises, seen;
    logic prev;
    bit   s, lb, hold, prev_hold;
    rst_n = 1'b0; tx_valid = 1'b0; hold_cs = 1'b0; sel = 1'b0; loopback = 1'b1;
    tx_data = 8'h00; slave_byte = 8'h00;
    repeat (3) tick();
    checkOutput("reset_outputs", {ready, cs, sclk, busy, rxv, mosi, oe, mode}, 9'b0_1_0_0_0_0_1_00);
    checkOutput("reset_rx_data", rxd, 8'h00);
    rst_n = 1'b1;
    tick();
    checkOutput("ready_after_reset", ready, 1);

    $display("[TB] directed transfers");
    applyStimulus(0, 8'hA5, 8'h00, 1, 0, 0);
    applyStimulus(0, 8'hC3, 8'h3C, 0, 0, 0);
    applyStimulus(0, 8'h01, 8'h00, 1, 1, 0);
    applyStimulus(0, 8'h80, 8'h00, 1, 0, 0);
    applyStimulus(0, 8'h69, 8'h00, 1, 0, 1);
    applyStimulus(1, 8'h96, 8'h00, 1, 0, 0);

    $display("[TB] reset during transfer");
    sel = 1'b0; loopback = 1'b1; hold_cs = 1'b0; tx_data = 8'h33; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    rises = 0; prev = sclk;
    for (int i = 0; i < 100 && rises < 3; i++) begin
      tick();
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    checkOutput("reset_rise3", rises, 3);
    rst_n = 1'b0;
    tick();
    checkOutput("reset_mid_outputs", {cs, sclk, mode, rxv}, 5'b1_0_00_0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (rxv) seen = 1;
    end
    checkOutput("reset_no_rx", seen, 0);
    applyStimulus(0, 8'h5A, 8'h00, 1, 0, 0);

    $display("[TB] random transfers");
    prev_hold = 0;
    s = 0;
    for (int n = 0; n < 24; n++) begin
      if (!prev_hold) s = 1'($urandom_range(0, 1));
      lb   = 1'($urandom_range(0, 1));
      hold = (n == 23) ? 1'b0 : 1'($urandom_range(0, 1));
      applyStimulus(s, 8'($urandom), 8'($urandom), lb, hold, 1'($urandom_range(0, 1)));
      prev_hold = hold;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
